fb_rect_fill: RTL and testbench

FB_RECT_FILL -- requirements
Module: fb_rect_fill

---
 rtl/fb_rect_fill.sv | 162 ++++++++++++++++
 tb/tb_fb_rect_fill.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fb_rect_fill.sv
// Rectangle fill engine: clips a requested rectangle to the framebuffer and streams
// one solid-colour pixel write per accepted handshake, in raster order.
module fb_rect_fill #(
  parameter logic [31:0] FB_BASE_ADDR = 32'hD000_0000,
  parameter int unsigned FB_WIDTH     = 320,
  parameter int unsigned FB_HEIGHT    = 240
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [9:0]  x0,
  input  logic [9:0]  y0,
  input  logic [9:0]  w,
  input  logic [9:0]  h,
  input  logic [23:0] color,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {StIdle, StClip, StRun, StFin} state_e;

  localparam logic [10:0] WidthC  = 11'(FB_WIDTH);
  localparam logic [10:0] HeightC = 11'(FB_HEIGHT);
  localparam logic [31:0] Width32 = 32'(FB_WIDTH);

  state_e      state_q, state_d;
  logic [9:0]  x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
  logic [23:0] color_q, color_d;
  logic [10:0] xe_q, xe_d, ye_q, ye_d, cx_q, cx_d, cy_q, cy_d;
  logic [31:0] row_addr_q, row_addr_d, wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic        wr_valid_q, wr_valid_d, done_q, done_d, err_q, err_d;

  logic [10:0] x_end, y_end, cx_inc, cy_inc;
  logic [31:0] row_base;

  // 11-bit sums cannot overflow for 10-bit operands.
  assign x_end    = {1'b0, x0_q} + {1'b0, w_q};
  assign y_end    = {1'b0, y0_q} + {1'b0, h_q};
  assign cx_inc   = cx_q + 11'd1;
  assign cy_inc   = cy_q + 11'd1;
  assign row_base = FB_BASE_ADDR + 32'(y0_q) * Width32;

  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    w_d        = w_q;
    h_d        = h_q;
    color_d    = color_q;
    xe_d       = xe_q;
    ye_d       = ye_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    row_addr_d = row_addr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_valid_d = wr_valid_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          x0_d    = x0;
          y0_d    = y0;
          w_d     = w;
          h_d     = h;
          color_d = color;
          state_d = StClip;
        end
      end
      StClip: begin
        if (w_q == '0 || h_q == '0 || {1'b0, x0_q} >= WidthC || {1'b0, y0_q} >= HeightC) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          xe_d       = (x_end > WidthC) ? WidthC : x_end;
          ye_d       = (y_end > HeightC) ? HeightC : y_end;
          cx_d       = {1'b0, x0_q};
          cy_d       = {1'b0, y0_q};
          row_addr_d = row_base;
          wr_addr_d  = row_base + 32'(x0_q);
          wr_data_d  = {8'h00, color_q};
          wr_valid_d = 1'b1;
          state_d    = StRun;
        end
      end
      StRun: begin
        if (wr_valid_q && wr_ready) begin
          if (cx_inc < xe_q) begin
            cx_d      = cx_inc;
            wr_addr_d = row_addr_q + 32'(cx_inc);
          end else if (cy_inc < ye_q) begin
            cx_d       = {1'b0, x0_q};
            cy_d       = cy_inc;
            row_addr_d = row_addr_q + Width32;
            wr_addr_d  = row_addr_q + Width32 + 32'(x0_q);
          end else begin
            wr_valid_d = 1'b0;
            done_d     = 1'b1;
            state_d    = StFin;
          end
        end
      end
      StFin: begin
        wr_valid_d = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      xe_q       <= '0;
      ye_q       <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      row_addr_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      w_q        <= w_d;
      h_q        <= h_d;
      color_q    <= color_d;
      xe_q       <= xe_d;
      ye_q       <= ye_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      row_addr_q <= row_addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_valid_q <= wr_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Bench for fb_rect_fill: directed table, stall/restart/reset sequences and random fills,
// all checked against a raster-order address list built from the clipping rules.
module tb_fb_rect_fill;

  localparam logic [31:0] Base = 32'hD000_0000;
  localparam int          FbW  = 320;
  localparam int          FbH  = 240;

  logic        clk = 1'b0;
  logic        rst, start, wr_ready, wr_valid, busy, done, err;
  logic [9:0]  x0, y0, w, h;
  logic [23:0] color;
  logic [31:0] wr_addr, wr_data;

  int n_vec = 0;
  int n_mis = 0;
  logic [31:0] exp_q[$];

  fb_rect_fill dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .x0       (x0),
    .y0       (y0),
    .w        (w),
    .h        (h),
    .color    (color),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Expected pixel addresses, in raster order, for a request.
  task automatic model(input int mx, input int my, input int mw, input int mh, output bit rej);
    int xe, ye;
    exp_q.delete();
    rej = (mw == 0) || (mh == 0) || (mx >= FbW) || (my >= FbH);
    if (!rej) begin
      xe = (mx + mw < FbW) ? mx + mw : FbW;
      ye = (my + mh < FbH) ? my + mh : FbH;
      for (int yy = my; yy < ye; yy++)
        for (int xx = mx; xx < xe; xx++)
          exp_q.push_back(Base + 32'(yy * FbW + xx));
    end
  endtask

  // mode 0: ready always 1, 1: random ready, 2: ready pattern 1,0,0,1 then 1.
  task automatic run_fill(input int fx, input int fy, input int fw, input int fh,
                          input logic [23:0] fc, input int mode, input int restart_at,
                          output int cnt, output logic [31:0] first_a, output logic [31:0] last_a,
                          output bit saw_err);
    bit rej, pv, pr, rdy;
    logic [31:0] pa, pd, ea;
    int k, first_cyc, last_dec, done_cyc, err_cyc, n_done, n_err, pidx;
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    model(fx, fy, fw, fh, rej);
    cnt = 0; first_a = '0; last_a = '0; saw_err = 0;
    first_cyc = -1; last_dec = -1; done_cyc = -1; err_cyc = -1;
    n_done = 0; n_err = 0; pidx = 0; pv = 0; pr = 0; pa = '0; pd = '0;
    @(negedge clk);
    x0 = 10'(fx); y0 = 10'(fy); w = 10'(fw); h = 10'(fh); color = fc;
    start = 1'b1; wr_ready = 1'b0;
    k = 0;
    while (1) begin
      @(negedge clk);
      k++;
      start = (k == restart_at);
      if (k == restart_at) begin
        x0 = 10'd0; y0 = 10'd0; w = 10'd5; h = 10'd5; color = 24'hABCDEF;
      end
      if (err) begin n_err++; err_cyc = k; end
      if (done) begin n_done++; done_cyc = k; end
      chk("err_done_overlap", {31'd0, err & done}, 32'd0);
      chk("valid_outside_run", {31'd0, wr_valid & ~busy}, 32'd0);
      if (pv && !pr) begin
        chk("stall_valid", {31'd0, wr_valid}, 32'd1);
        chk("stall_addr", wr_addr, pa);
        chk("stall_data", wr_data, pd);
      end
      if (wr_valid && first_cyc < 0) first_cyc = k;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (pidx < 4) ? pat[pidx] : 1'b1;
      endcase
      if (wr_valid) pidx++;
      wr_ready = rdy;
      if (wr_valid && rdy) begin
        ea = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        chk("pixel_addr", wr_addr, ea);
        chk("pixel_data", wr_data, {8'h00, fc});
        if (cnt == 0) first_a = wr_addr;
        last_a = wr_addr;
        cnt++;
        last_dec = k;
      end
      pv = wr_valid; pr = rdy; pa = wr_addr; pd = wr_data;
      if (!busy && k >= 2) break;
      if (k > 2000) begin
        chk("timeout", 32'(k), 32'd0);
        break;
      end
    end
    wr_ready = 1'b0;
    start = 1'b0;
    saw_err = (n_err != 0);
    chk("writes_left", 32'(exp_q.size()), 32'd0);
    chk("err_count", 32'(n_err), rej ? 32'd1 : 32'd0);
    chk("done_count", 32'(n_done), rej ? 32'd0 : 32'd1);
    if (rej) begin
      chk("err_latency", 32'(err_cyc), 32'd2);
      chk("no_writes", 32'(cnt), 32'd0);
    end else begin
      chk("first_latency", 32'(first_cyc), 32'd2);
      chk("done_after_last", 32'(done_cyc), 32'(last_dec + 1));
    end
  endtask

  typedef struct {
    int          x0, y0, w, h;
    logic [23:0] color;
    bit          exp_err;
    int          exp_cnt;
    logic [31:0] exp_first, exp_last;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int cnt, nacc;
    logic [31:0] fa, la;
    bit se;

    vecs[0] = '{0, 0, 2, 2, 24'h112233, 1'b0, 4, 32'hD000_0000, 32'hD000_0141};
    vecs[1] = '{318, 239, 10, 10, 24'h445566, 1'b0, 2, 32'hD001_2BFE, 32'hD001_2BFF};
    vecs[2] = '{5, 0, 0, 3, 24'h010203, 1'b1, 0, 32'h0, 32'h0};
    vecs[3] = '{320, 0, 4, 4, 24'h0A0B0C, 1'b1, 0, 32'h0, 32'h0};
    vecs[4] = '{0, 240, 1, 1, 24'hFFFFFF, 1'b1, 0, 32'h0, 32'h0};
    vecs[5] = '{1, 1, 3, 0, 24'h123456, 1'b1, 0, 32'h0, 32'h0};
    vecs[6] = '{319, 0, 1, 1, 24'h00FF00, 1'b0, 1, 32'hD000_013F, 32'hD000_013F};
    vecs[7] = '{10, 20, 3, 1, 24'h7F7F7F, 1'b0, 3, 32'hD000_190A, 32'hD000_190C};
    vecs[8] = '{0, 238, 1, 5, 24'h800000, 1'b0, 2, 32'hD001_2980, 32'hD001_2AC0};
    vecs[9] = '{1023, 1023, 1023, 1023, 24'h000001, 1'b1, 0, 32'h0, 32'h0};

    rst = 1'b1; start = 1'b0; wr_ready = 1'b0;
    x0 = '0; y0 = '0; w = '0; h = '0; color = '0;
    repeat (3) @(negedge clk);
    chk("reset_valid", {31'd0, wr_valid}, 32'd0);
    chk("reset_addr", wr_addr, 32'd0);
    chk("reset_data", wr_data, 32'd0);
    chk("reset_flags", {29'd0, busy, done, err}, 32'd0);
    // Reset outranks a simultaneous start.
    start = 1'b1; w = 10'd2; h = 10'd2;
    @(negedge clk);
    chk("rst_over_start", {31'd0, busy}, 32'd0);
    start = 1'b0;
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_fill(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h, vecs[i].color, 0, -1,
               cnt, fa, la, se);
      chk($sformatf("vec%0d_err", i), {31'd0, se}, {31'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_count", i), 32'(cnt), 32'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d_first", i), fa, vecs[i].exp_first);
      chk($sformatf("vec%0d_last", i), la, vecs[i].exp_last);
    end

    // Stalled 3-pixel fill.
    run_fill(4, 2, 3, 1, 24'h334455, 2, -1, cnt, fa, la, se);
    chk("stall_count", 32'(cnt), 32'd3);

    // Start pulsed while busy must be ignored.
    run_fill(7, 9, 3, 2, 24'h5A5A5A, 0, 3, cnt, fa, la, se);
    chk("restart_count", 32'(cnt), 32'd6);
    repeat (3) begin
      @(negedge clk);
      chk("restart_idle", {30'd0, busy, wr_valid}, 32'd0);
    end

    // Reset in the middle of a 4x4 fill.
    @(negedge clk);
    x0 = 10'd0; y0 = 10'd0; w = 10'd4; h = 10'd4; color = 24'h999999;
    start = 1'b1; wr_ready = 1'b1;
    nacc = 0;
    for (int k = 0; k < 40 && nacc < 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (wr_valid) nacc++;
    end
    chk("abort_accepts", 32'(nacc), 32'd5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_valid", {31'd0, wr_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    repeat (6) begin
      @(negedge clk);
      chk("abort_quiet", {29'd0, wr_valid, done, busy}, 32'd0);
    end
    wr_ready = 1'b0;

    // Random fills with random back-pressure.
    for (int i = 0; i < 25; i++) begin
      run_fill(int'($urandom_range(0, 330)), int'($urandom_range(0, 250)),
               int'($urandom_range(0, 12)), int'($urandom_range(0, 6)),
               24'($urandom), 1, -1, cnt, fa, la, se);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
